// File: rtl/track_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : track_mode_sequencer
// Description : Line-following supervisor for the two-wheel car. Debounces
//               the 3-bit IR line sensor, tracks an obstacle flag from the
//               ultrasonic range strobe, and sequences the steering mode and
//               motor-enable seen by the motor block.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               start, stop   - one-cycle command pulses
//               sensor[2:0]   - raw IR {L,C,R}, 1 = line under sensor
//               dist_cm[8:0]  - ultrasonic distance (cm), new on dist_valid
//               mode[2:0]     - registered steering mode
//               run           - registered motor enable
//               fault         - sticky "line lost, retries exhausted"
//               state[2:0]    - IDLE=0 TRACK=1 LOST=2 REVERSE=3 HALT=4
// Revision    : 1.0 - initial release
// ============================================================================
module track_mode_sequencer #(
    parameter int FILT_CYC  = 1000,
    parameter int LOST_CYC  = 50_000_000,
    parameter int REV_CYC   = 30_000_000,
    parameter int MAX_RETRY = 3,
    parameter int OBST_CM   = 20,
    parameter int HYST_CM   = 5,
    parameter int CLEAR_CYC = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [2:0] sensor,
    input  logic [8:0] dist_cm,
    input  logic       dist_valid,
    output logic [2:0] mode,
    output logic       run,
    output logic       fault,
    output logic [2:0] state
);

    // One shared counter width sized for the longest interval.
    localparam int c_max_ab  = (FILT_CYC > LOST_CYC) ? FILT_CYC : LOST_CYC;
    localparam int c_max_cd  = (REV_CYC > CLEAR_CYC) ? REV_CYC : CLEAR_CYC;
    localparam int c_max_cyc = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_cnt_w   = ($clog2(c_max_cyc) < 1) ? 1 : $clog2(c_max_cyc);
    localparam int c_retry_w = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [c_cnt_w-1:0]   c_filt_last  = c_cnt_w'(FILT_CYC - 1);
    localparam logic [c_cnt_w-1:0]   c_lost_last  = c_cnt_w'(LOST_CYC - 1);
    localparam logic [c_cnt_w-1:0]   c_rev_last   = c_cnt_w'(REV_CYC - 1);
    localparam logic [c_cnt_w-1:0]   c_clear_last = c_cnt_w'(CLEAR_CYC - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_retry_w-1:0] c_retry_max  = c_retry_w'(MAX_RETRY);
    localparam logic [c_retry_w-1:0] c_retry_one  = c_retry_w'(1);
    localparam logic [8:0]           c_obst_cm    = 9'(OBST_CM);
    localparam logic [8:0]           c_release_cm = 9'(OBST_CM + HYST_CM);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRACK   = 3'd1,
        ST_LOST    = 3'd2,
        ST_REVERSE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    state_t               r_state;
    logic [2:0]           r_mode;
    logic                 r_run;
    logic                 r_fault;
    logic [2:0]           r_sensor_prev;
    logic [2:0]           r_filt;
    logic [c_cnt_w-1:0]   r_filt_cnt;
    logic [c_cnt_w-1:0]   r_lost_cnt;
    logic [c_cnt_w-1:0]   r_rev_cnt;
    logic [c_cnt_w-1:0]   r_clear_cnt;
    logic [c_retry_w-1:0] r_retry;
    logic                 r_obst;

    assign mode  = r_mode;
    assign run   = r_run;
    assign fault = r_fault;
    assign state = r_state;

    // Sensor debounce: any raw change restarts the stability count; the
    // filtered value only follows once the raw value has held long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sensor_prev <= 3'b000;
            r_filt_cnt    <= '0;
            r_filt        <= 3'b000;
        end else if (sensor != r_sensor_prev) begin
            r_sensor_prev <= sensor;
            r_filt_cnt    <= '0;
        end else if (r_filt_cnt == c_filt_last) begin
            r_filt        <= sensor;
        end else begin
            r_filt_cnt    <= r_filt_cnt + c_cnt_one;
        end
    end

    // Obstacle flag with hysteresis; only updated on a fresh range strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_obst <= 1'b0;
        end else if (dist_valid) begin
            if (dist_cm < c_obst_cm) begin
                r_obst <= 1'b1;
            end else if (dist_cm >= c_release_cm) begin
                r_obst <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= 3'b111;
            r_run       <= 1'b0;
            r_fault     <= 1'b0;
            r_lost_cnt  <= '0;
            r_rev_cnt   <= '0;
            r_clear_cnt <= '0;
            r_retry     <= '0;
        end else begin
            // Outputs are decoded from the state held during this cycle, so
            // they follow a transition one clock later.
            unique case (r_state)
                ST_IDLE: begin
                    r_run  <= 1'b0;
                    r_mode <= 3'b111;
                end
                ST_TRACK: begin
                    r_run <= 1'b1;
                    // Centre-only reads as straight ahead; both edges without
                    // the centre is ambiguous, so keep steering as before.
                    if (r_filt == 3'b010) begin
                        r_mode <= 3'b111;
                    end else if (r_filt != 3'b101) begin
                        r_mode <= r_filt;
                    end
                end
                ST_LOST: begin
                    r_run  <= 1'b1;
                    r_mode <= 3'b000;
                end
                ST_REVERSE: begin
                    r_run  <= 1'b1;
                    r_mode <= 3'b010;
                end
                ST_HALT: begin
                    r_run <= 1'b0;
                end
                default: begin
                    r_run  <= 1'b0;
                    r_mode <= 3'b111;
                end
            endcase

            if (stop) begin
                r_state <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_TRACK;
                            r_retry <= '0;
                            r_fault <= 1'b0;
                        end
                    end
                    ST_TRACK: begin
                        if (r_obst) begin
                            r_state     <= ST_HALT;
                            r_clear_cnt <= '0;
                        end else if (r_filt == 3'b000) begin
                            r_state    <= ST_LOST;
                            r_lost_cnt <= '0;
                        end
                    end
                    ST_LOST: begin
                        if (r_obst) begin
                            r_state     <= ST_HALT;
                            r_clear_cnt <= '0;
                        end else if (r_filt != 3'b000) begin
                            r_state <= ST_TRACK;
                            r_retry <= '0;
                        end else if (r_lost_cnt == c_lost_last) begin
                            if (r_retry < c_retry_max) begin
                                r_state   <= ST_REVERSE;
                                r_retry   <= r_retry + c_retry_one;
                                r_rev_cnt <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_fault <= 1'b1;
                            end
                        end else begin
                            r_lost_cnt <= r_lost_cnt + c_cnt_one;
                        end
                    end
                    ST_REVERSE: begin
                        // Obstacles are deliberately ignored while backing up.
                        if (r_rev_cnt == c_rev_last) begin
                            if (r_filt != 3'b000) begin
                                r_state <= ST_TRACK;
                                r_retry <= '0;
                            end else begin
                                r_state    <= ST_LOST;
                                r_lost_cnt <= '0;
                            end
                        end else begin
                            r_rev_cnt <= r_rev_cnt + c_cnt_one;
                        end
                    end
                    ST_HALT: begin
                        if (r_obst) begin
                            r_clear_cnt <= '0;
                        end else if (r_clear_cnt == c_clear_last) begin
                            r_state <= ST_TRACK;
                        end else begin
                            r_clear_cnt <= r_clear_cnt + c_cnt_one;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_track_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_track_mode_sequencer
// Description : Directed self-checking bench for track_mode_sequencer using
//               short timing parameters and hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_track_mode_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [2:0] sensor;
    logic [8:0] dist_cm;
    logic       dist_valid;
    logic [2:0] mode;
    logic       run;
    logic       fault;
    logic [2:0] state;

    int n_vec;
    int n_err;

    track_mode_sequencer #(
        .FILT_CYC  (4),
        .LOST_CYC  (20),
        .REV_CYC   (10),
        .MAX_RETRY (2),
        .OBST_CM   (20),
        .HYST_CM   (5),
        .CLEAR_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .sensor     (sensor),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .mode       (mode),
        .run        (run),
        .fault      (fault),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        sensor     = 3'b000;
        dist_cm    = 9'd100;
        dist_valid = 1'b0;

        // Reset values
        tick(2);
        check("rst_state", {5'd0, state}, 8'd0);
        check("rst_mode",  {5'd0, mode},  8'h07);
        check("rst_run",   {7'd0, run},   8'd0);
        check("rst_fault", {7'd0, fault}, 8'd0);
        rst = 1'b0;

        // Filter settles to 110 (change seen, then 4 stable edges), then start
        sensor = 3'b110;
        tick(5);
        check("idle_before_start", {5'd0, state}, 8'd0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_to_track", {5'd0, state}, 8'd1);
        tick(1);
        check("track_mode_110", {5'd0, mode}, 8'h06);
        check("track_run",      {7'd0, run},  8'd1);

        // Two-cycle glitch must be rejected by the filter
        sensor = 3'b011;
        tick(2);
        sensor = 3'b110;
        tick(3);
        check("glitch_mode_hold", {5'd0, mode}, 8'h06);

        // Obstacle at 15 cm -> HALT
        dist_cm    = 9'd15;
        dist_valid = 1'b1;
        tick(1);
        dist_valid = 1'b0;
        tick(1);
        check("obst_to_halt", {5'd0, state}, 8'd4);
        tick(1);
        check("halt_run",       {7'd0, run},  8'd0);
        check("halt_mode_hold", {5'd0, mode}, 8'h06);

        // 22 cm lies inside the hysteresis band: obstacle stays asserted
        dist_cm    = 9'd22;
        dist_valid = 1'b1;
        tick(1);
        dist_valid = 1'b0;
        tick(12);
        check("hyst_stay_halt", {5'd0, state}, 8'd4);

        // 25 cm releases; exactly 8 clear cycles needed before TRACK
        dist_cm    = 9'd25;
        dist_valid = 1'b1;
        tick(1);
        dist_valid = 1'b0;
        tick(7);
        check("clear_7_still_halt", {5'd0, state}, 8'd4);
        tick(1);
        check("clear_8_track", {5'd0, state}, 8'd1);
        tick(1);
        check("resume_run", {7'd0, run}, 8'd1);

        // Line lost for good: LOST 20, REVERSE 10, LOST 20, REVERSE 10, LOST 20 -> fault
        sensor = 3'b000;
        tick(6);
        check("lost_entry", {5'd0, state}, 8'd2);
        tick(1);
        check("lost_mode", {5'd0, mode}, 8'h00);
        check("lost_run",  {7'd0, run},  8'd1);
        tick(18);
        check("lost_cyc19_still_lost", {5'd0, state}, 8'd2);
        tick(1);
        check("lost_to_rev1", {5'd0, state}, 8'd3);
        tick(1);
        check("rev_mode", {5'd0, mode}, 8'h02);
        tick(9);
        check("rev1_to_lost", {5'd0, state}, 8'd2);
        tick(20);
        check("lost_to_rev2", {5'd0, state}, 8'd3);
        tick(10);
        check("rev2_to_lost", {5'd0, state}, 8'd2);
        tick(20);
        check("giveup_idle",  {5'd0, state}, 8'd0);
        check("giveup_fault", {7'd0, fault}, 8'd1);
        tick(1);
        check("giveup_run",  {7'd0, run},  8'd0);
        check("giveup_mode", {5'd0, mode}, 8'h07);

        // Restart clears fault; line found again while reversing
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("restart_track", {5'd0, state}, 8'd1);
        check("restart_fault", {7'd0, fault}, 8'd0);
        tick(21);
        check("rev_again", {5'd0, state}, 8'd3);
        sensor = 3'b111;
        tick(9);
        check("rev_full_duration", {5'd0, state}, 8'd3);
        tick(1);
        check("rev_to_track",      {5'd0, state},      8'd1);
        check("retry_cleared",     {6'd0, dut.r_retry}, 8'd0);
        tick(1);
        check("rev_track_mode_111", {5'd0, mode}, 8'h07);

        // Mode mapping in TRACK: plain follow, 101 holds, 010 -> 111
        sensor = 3'b100;
        tick(7);
        check("map_100", {5'd0, mode}, 8'h04);
        sensor = 3'b101;
        tick(7);
        check("map_101_hold", {5'd0, mode}, 8'h04);
        sensor = 3'b010;
        tick(7);
        check("map_010_fwd", {5'd0, mode}, 8'h07);

        // stop and start together: stop wins
        stop  = 1'b1;
        start = 1'b1;
        tick(1);
        stop  = 1'b0;
        start = 1'b0;
        check("stop_wins", {5'd0, state}, 8'd0);
        tick(1);
        check("stop_run", {7'd0, run}, 8'd0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_after_stop", {5'd0, state}, 8'd1);
        check("start_fault_clr",  {7'd0, fault}, 8'd0);

        // Asynchronous reset in the middle of LOST
        sensor = 3'b000;
        tick(7);
        check("pre_rst_lost", {5'd0, state}, 8'd2);
        check("pre_rst_run",  {7'd0, run},   8'd1);
        rst = 1'b1;
        #1;
        check("async_rst_state", {5'd0, state}, 8'd0);
        check("async_rst_mode",  {5'd0, mode},  8'h07);
        check("async_rst_run",   {7'd0, run},   8'd0);
        check("async_rst_fault", {7'd0, fault}, 8'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("post_rst_idle", {5'd0, state}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
